// File: rtl/buttfly_err_acc.sv
// rtl/buttfly_err_acc.sv - streaming accuracy monitor for a butterfly partition
// Two-stage pipeline: per-sample distance metrics, then windowed accumulation.
module buttfly_err_acc #(
  parameter int          W      = 10,
  parameter int          CNT_W  = 16,
  parameter int unsigned SIGNED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       win_len,
  input  logic                   in_valid,
  input  logic [W-1:0]           exact,
  input  logic [W-1:0]           approx,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [W+CNT_W:0]       sum_ed,
  output logic [W:0]             max_ed,
  output logic [CNT_W+3:0]       sum_hd
);

  localparam int ED_W  = W + 1;
  localparam int SED_W = W + 1 + CNT_W;
  localparam int SED_X = SED_W + 1;
  localparam int SHD_W = CNT_W + 4;
  localparam int SHD_X = SHD_W + 1;
  localparam int HD_W  = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_vld_q, s1_vld_d;
  logic [ED_W-1:0]  s1_ed_q, s1_ed_d;
  logic             s1_neq_q, s1_neq_d;
  logic [HD_W-1:0]  s1_hd_q, s1_hd_d;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SED_W-1:0] sum_ed_q, sum_ed_d;
  logic [ED_W-1:0]  max_ed_q, max_ed_d;
  logic [SHD_W-1:0] sum_hd_q, sum_hd_d;

  logic             start_ok;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  logic [ED_W-1:0]  ex_ext, ap_ext, diff;
  logic [W-1:0]     xr;
  logic [SED_X-1:0] sed_sum;
  logic [SHD_X-1:0] shd_sum;

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept   = in_valid && (state_q == ST_RUN);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Control: the window closes on the cycle the last sample is accepted.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          len_d   = (win_len == '0) ? CNT_W'(1) : win_len;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Stage 2 has already committed the last sample once stage 1 is empty.
        if (!s1_vld_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 1: distance metrics computed with one extra bit so |diff| never wraps.
  always_comb begin
    if (SIGNED != 0) begin
      ex_ext = {exact[W-1], exact};
      ap_ext = {approx[W-1], approx};
    end else begin
      ex_ext = {1'b0, exact};
      ap_ext = {1'b0, approx};
    end
    diff     = ex_ext - ap_ext;
    s1_ed_d  = diff[W] ? ((~diff) + ED_W'(1)) : diff;
    s1_neq_d = (exact != approx);
    xr       = exact ^ approx;
    s1_hd_d  = '0;
    for (int i = 0; i < W; i++) begin
      s1_hd_d = s1_hd_d + HD_W'(xr[i]);
    end
    s1_vld_d = accept;
  end

  // Stage 2: saturating accumulation; a start clears the whole window.
  always_comb begin
    err_cnt_d = err_cnt_q;
    sum_ed_d  = sum_ed_q;
    max_ed_d  = max_ed_q;
    sum_hd_d  = sum_hd_q;
    sed_sum   = {1'b0, sum_ed_q} + SED_X'(s1_ed_q);
    shd_sum   = {1'b0, sum_hd_q} + SHD_X'(s1_hd_q);
    if (start_ok) begin
      err_cnt_d = '0;
      sum_ed_d  = '0;
      max_ed_d  = '0;
      sum_hd_d  = '0;
    end else if (s1_vld_q) begin
      err_cnt_d = err_cnt_q + CNT_W'(s1_neq_q);
      sum_ed_d  = sed_sum[SED_W] ? '1 : sed_sum[SED_W-1:0];
      sum_hd_d  = shd_sum[SHD_W] ? '1 : shd_sum[SHD_W-1:0];
      if (s1_ed_q > max_ed_q) max_ed_d = s1_ed_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_ed_q   <= '0;
      s1_neq_q  <= 1'b0;
      s1_hd_q   <= '0;
      err_cnt_q <= '0;
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
      sum_hd_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_ed_q   <= s1_ed_d;
      s1_neq_q  <= s1_neq_d;
      s1_hd_q   <= s1_hd_d;
      err_cnt_q <= err_cnt_d;
      sum_ed_q  <= sum_ed_d;
      max_ed_q  <= max_ed_d;
      sum_hd_q  <= sum_hd_d;
    end
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);
  assign err_cnt = err_cnt_q;
  assign sum_ed  = sum_ed_q;
  assign max_ed  = max_ed_q;
  assign sum_hd  = sum_hd_q;

endmodule

// File: tb/tb_buttfly_err_acc.sv
// tb/tb_buttfly_err_acc.sv - self-checking bench for buttfly_err_acc
// Signed and unsigned instances share stimulus; each window result is scoreboarded.
module tb_buttfly_err_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] win_len;
  logic        in_valid;
  logic [9:0]  exact, approx;

  logic        busy_s, done_s, busy_u, done_u;
  logic [15:0] err_cnt_s, err_cnt_u;
  logic [26:0] sum_ed_s, sum_ed_u;
  logic [10:0] max_ed_s, max_ed_u;
  logic [19:0] sum_hd_s, sum_hd_u;

  buttfly_err_acc #(.W(10), .CNT_W(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .in_valid(in_valid),
    .exact(exact), .approx(approx), .busy(busy_s), .done(done_s),
    .err_cnt(err_cnt_s), .sum_ed(sum_ed_s), .max_ed(max_ed_s), .sum_hd(sum_hd_s)
  );

  buttfly_err_acc #(.W(10), .CNT_W(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .in_valid(in_valid),
    .exact(exact), .approx(approx), .busy(busy_u), .done(done_u),
    .err_cnt(err_cnt_u), .sum_ed(sum_ed_u), .max_ed(max_ed_u), .sum_hd(sum_hd_u)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      win_len;
    int               n;
    logic [3:0][9:0]  ex;
    logic [3:0][9:0]  ap;
    bit               sgn;
    logic [15:0]      e_err;
    logic [26:0]      e_sed;
    logic [10:0]      e_max;
    logic [19:0]      e_shd;
  } vec_t;

  typedef struct {
    bit          sgn;
    logic [15:0] err;
    logic [26:0] sed;
    logic [10:0] mx;
    logic [19:0] shd;
  } exp_t;

  vec_t vt[6];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] wl, input int n,
                               input logic [3:0][9:0] ex, input logic [3:0][9:0] ap,
                               input bit sgn, input logic [15:0] e_err, input logic [26:0] e_sed,
                               input logic [10:0] e_max, input logic [19:0] e_shd);
    vec_t v;
    v.win_len = wl; v.n = n; v.ex = ex; v.ap = ap; v.sgn = sgn;
    v.e_err = e_err; v.e_sed = e_sed; v.e_max = e_max; v.e_shd = e_shd;
    return v;
  endfunction

  function automatic exp_t mke(input bit sgn, input logic [15:0] err, input logic [26:0] sed,
                               input logic [10:0] mx, input logic [19:0] shd);
    exp_t e;
    e.sgn = sgn; e.err = err; e.sed = sed; e.mx = mx; e.shd = shd;
    return e;
  endfunction

  task automatic start_win(input logic [15:0] wl);
    @(negedge clk);
    start = 1'b1; win_len = wl; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [9:0] ex, input logic [9:0] ap);
    in_valid = v; exact = ex; approx = ap;
    @(negedge clk);
  endtask

  // Called at the negedge after the last accepted sample's edge (cycle t+1).
  task automatic wait_done(input string tag, input int exp_k);
    int k = 0;
    while (!done_s && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, exp_k);
    chk({tag, "_done_u"}, done_u, 1'b1);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: got empty scoreboard, expected an entry", tag);
    end else begin
      n_chk--;
      e = sb.pop_front();
      if (e.sgn) begin
        chk({tag, "_err_cnt"}, err_cnt_s, e.err);
        chk({tag, "_sum_ed"},  sum_ed_s,  e.sed);
        chk({tag, "_max_ed"},  max_ed_s,  e.mx);
        chk({tag, "_sum_hd"},  sum_hd_s,  e.shd);
      end else begin
        chk({tag, "_err_cnt"}, err_cnt_u, e.err);
        chk({tag, "_sum_ed"},  sum_ed_u,  e.sed);
        chk({tag, "_max_ed"},  max_ed_u,  e.mx);
        chk({tag, "_sum_hd"},  sum_hd_u,  e.shd);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    busy_s,    1'b0);
    chk({tag, "_done"},    done_s,    1'b0);
    chk({tag, "_err_cnt"}, err_cnt_s, 0);
    chk({tag, "_sum_ed"},  sum_ed_s,  0);
    chk({tag, "_max_ed"},  max_ed_s,  0);
    chk({tag, "_sum_hd"},  sum_hd_s,  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    vt[0] = mkv(16'd4, 4, {4{10'h155}}, {4{10'h155}}, 1'b1, 16'd0, 27'd0, 11'd0, 20'd0);
    vt[1] = mkv(16'd2, 2, {10'h0, 10'h0, 10'h001, 10'h200}, {10'h0, 10'h0, 10'h000, 10'h1FF},
                1'b1, 16'd2, 27'd1024, 11'd1023, 20'd11);
    vt[2] = mkv(16'd1, 1, {10'h0, 10'h0, 10'h0, 10'h3FF}, {10'h0, 10'h0, 10'h0, 10'h000},
                1'b0, 16'd1, 27'd1023, 11'd1023, 20'd10);
    vt[3] = mkv(16'd3, 3, {10'h0, 10'h010, 10'h3FF, 10'h005}, {10'h0, 10'h010, 10'h001, 10'h003},
                1'b1, 16'd2, 27'd4, 11'd2, 20'd11);
    vt[4] = mkv(16'd3, 3, {10'h0, 10'h010, 10'h3FF, 10'h005}, {10'h0, 10'h010, 10'h001, 10'h003},
                1'b0, 16'd2, 27'd1024, 11'd1022, 20'd11);
    vt[5] = mkv(16'd0, 1, {10'h0, 10'h0, 10'h0, 10'h00F}, {10'h0, 10'h0, 10'h0, 10'h000},
                1'b1, 16'd1, 27'd15, 11'd15, 20'd4);

    rst = 1'b1; start = 1'b0; win_len = '0; in_valid = 1'b0; exact = '0; approx = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("reset_busy_u", busy_u, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a window.
    start_win(16'd8);
    chk("mid_busy", busy_s, 1'b1);
    drive(1'b1, 10'h001, 10'h000);
    drive(1'b1, 10'h0F0, 10'h00F);
    drive(1'b1, 10'h3FF, 10'h000);
    drive(1'b0, 10'h000, 10'h000);
    chk("mid_err_cnt", err_cnt_s, 3);
    chk("mid_sum_ed",  sum_ed_s,  227);
    chk("mid_max_ed",  max_ed_s,  225);
    chk("mid_sum_hd",  sum_hd_s,  19);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 10'h3FF, 10'h000);
    in_valid = 1'b0;
    chk_zero("post_rst");

    // Table-driven windows, back-to-back samples.
    for (int v = 0; v < 6; v++) begin
      start_win(vt[v].win_len);
      sb.push_back(mke(vt[v].sgn, vt[v].e_err, vt[v].e_sed, vt[v].e_max, vt[v].e_shd));
      for (int i = 0; i < vt[v].n; i++) drive(1'b1, vt[v].ex[i], vt[v].ap[i]);
      in_valid = 1'b0;
      wait_done($sformatf("vec%0d", v), 2);
      check_pop($sformatf("vec%0d", v));
    end

    // Restart from DONE clears the accumulators immediately.
    start_win(16'd2);
    chk("restart_done",    done_s,    1'b0);
    chk("restart_busy",    busy_s,    1'b1);
    chk("restart_err_cnt", err_cnt_s, 0);
    chk("restart_sum_ed",  sum_ed_s,  0);
    chk("restart_max_ed",  max_ed_s,  0);
    chk("restart_sum_hd",  sum_hd_s,  0);
    sb.push_back(mke(1'b1, 16'd2, 27'd4, 11'd3, 20'd4));
    drive(1'b1, 10'h002, 10'h001);
    drive(1'b1, 10'h000, 10'h003);
    in_valid = 1'b0;
    wait_done("restart", 2);
    check_pop("restart");

    // Gapped valid; valids after the window closes are ignored.
    start_win(16'd3);
    sb.push_back(mke(1'b1, 16'd3, 27'd6, 11'd3, 20'd4));
    drive(1'b1, 10'h001, 10'h000);
    drive(1'b0, 10'h3FF, 10'h000);
    drive(1'b0, 10'h3FF, 10'h000);
    drive(1'b1, 10'h002, 10'h000);
    drive(1'b1, 10'h003, 10'h000);
    in_valid = 1'b1; exact = 10'h3FF; approx = 10'h000;
    wait_done("gapped", 2);
    in_valid = 1'b0;
    @(negedge clk);
    check_pop("gapped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/buttfly_err_acc.md
Name: buttfly_err_acc

Overview:
- Streaming accuracy monitor that sits directly downstream of a butterfly partition.
- Each valid cycle it takes the partition's exact and approximate 10-bit output vectors. Over a programmable window of samples it accumulates error rate, sum of absolute error distance, maximum error distance and total bit-flip (Hamming) count.
- Used in hardware-in-loop accuracy evaluation of approximate partitions. Results are held until the next start.

Parameters:
- W, 10, data width of the exact/approx vectors; bit W-1 is the MSB (partition output po00)
- CNT_W, 16, width of the window length and the sample/error counters
- SIGNED, 1, 1 = vectors are two's complement, 0 = unsigned

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a window; ignored unless state is IDLE or DONE
- win_len  input  CNT_W  number of samples in the window; sampled on start; 0 is treated as 1
- in_valid  input  1  exact/approx pair valid this cycle
- exact  input  W  exact partition output
- approx  input  W  approximate partition output
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE; results are stable while done is high
- err_cnt  output  CNT_W  number of samples with exact != approx
- sum_ed  output  W+1+CNT_W  sum of |exact - approx|, saturating
- max_ed  output  W+1  maximum |exact - approx| in the window
- sum_hd  output  CNT_W+4  sum of popcount(exact ^ approx), saturating

Behaviour:
- Reset (async, any state, including mid-window):
  - state = IDLE; all counters and outputs = 0.
  - busy = 0, done = 0.
  - The pipeline valid bits are cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: clear all accumulators, latch len = max(win_len, 1), clear sample count, go to RUN. done falls the cycle after start.
  - RUN: each in_valid cycle accepts one sample and increments the sample count. The cycle the count reaches len, go to DRAIN. in_valid in later cycles is ignored.
  - DRAIN: wait until both pipeline stages are empty (2 cycles), then go to DONE.
  - DONE: hold results. Another start restarts the window.
  - start while in RUN or DRAIN is ignored.
- Pipeline:
  - Stage 1 registers three values:
    - ed = |exact - approx|, computed in W+1 bits, sign-extended when SIGNED=1 and zero-extended when SIGNED=0.
    - neq = (exact != approx).
    - hd = popcount(exact ^ approx).
  - Stage 2 updates the accumulators:
    - err_cnt += neq
    - sum_ed += ed
    - sum_hd += hd
    - max_ed = max(max_ed, ed)
- Latency:
  - The last sample is accepted in cycle t. Its stage-1 register updates at t+1 and the accumulators at t+2.
  - done = 1 at t+3.
  - Accumulator outputs update live during RUN; they are valid for the complete window only while done = 1.
- Arithmetic:
  - Worst-case ED is 1023 for both SIGNED settings: 10-bit signed, -512 vs 511; 10-bit unsigned, 0 vs 1023.
  - sum_ed and sum_hd saturate at all-ones and never wrap.
  - err_cnt cannot exceed len, so it never overflows.
- Back-to-back:
  - in_valid may be high every cycle, with no bubbles required.
  - No backpressure: the monitor never stalls its source.
- A sample arriving in the same cycle as start is not counted; the window begins the following cycle.

Test Plan:
- Reset mid-window: start, win_len=8, 3 valid samples, then assert rst -> same cycle: busy=0, done=0, all counters 0; after release, state=IDLE and in_valid is ignored.
- Exact match: win_len=4, four samples with exact=approx=10'h155 -> done at t+3; err_cnt=0, sum_ed=0, max_ed=0, sum_hd=0.
- Signed extremes: SIGNED=1, win_len=2, pairs (10'h200, 10'h1FF) and (10'h001, 10'h000) -> err_cnt=2, sum_ed=1024, max_ed=1023, sum_hd=11.
- Unsigned mode: SIGNED=0, win_len=1, pair (10'h3FF, 10'h000) -> err_cnt=1, sum_ed=1023, max_ed=1023, sum_hd=10.
- Gapped valid and window end: win_len=3, in_valid pattern 1,0,0,1,1,1 -> only the first three valid samples are counted; the 4th valid is ignored; done asserts 3 cycles after the 3rd accepted sample.
- win_len=0 plus restart: win_len=0 with one sample -> treated as 1, done asserts. Then start with win_len=2 while done=1 -> done falls next cycle and accumulators clear to 0.
